mu_pingpong: RTL and testbench

Ping-pong complex memory unit for the in-place radix-2 FFT datapath. It holds two complex banks (real and imaginary), each 2^ADDR_WIDTH deep. Butterflies read an A/B pair from the active "read" bank and write results into the other bank; a `swap` pulse exchanges the roles at each stage boundary. A separate load port fills the read bank with input samples, in natural or bit-reversed order, before the first stage.

---
 rtl/mu_pingpong_if.sv | 47 ++++
 rtl/mu_pingpong.sv | 82 ++++++++
 tb/tb_mu_pingpong.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mu_pingpong_if.sv
// Bus bundle for the ping-pong memory unit: butterfly read/write ports,
// sample load port and bank status. The controller is master, the memory is slave.
interface mu_pingpong_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 5
);
   logic                  swap;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] A_addr;
   logic [ADDR_WIDTH-1:0] B_addr;
   logic [DATA_WIDTH-1:0] A_real_out;
   logic [DATA_WIDTH-1:0] A_imag_out;
   logic [DATA_WIDTH-1:0] B_real_out;
   logic [DATA_WIDTH-1:0] B_imag_out;
   logic                  rd_valid;
   logic                  wr_en;
   logic                  singlewrite;
   logic [ADDR_WIDTH-1:0] WA_addr;
   logic [ADDR_WIDTH-1:0] WB_addr;
   logic [DATA_WIDTH-1:0] A_real_in;
   logic [DATA_WIDTH-1:0] A_imag_in;
   logic [DATA_WIDTH-1:0] B_real_in;
   logic [DATA_WIDTH-1:0] B_imag_in;
   logic                  ld_en;
   logic [ADDR_WIDTH-1:0] ld_addr;
   logic [DATA_WIDTH-1:0] ld_real;
   logic [DATA_WIDTH-1:0] ld_imag;
   logic                  bank_sel;

   modport master (
      output swap, rd_en, A_addr, B_addr,
      output wr_en, singlewrite, WA_addr, WB_addr,
      output A_real_in, A_imag_in, B_real_in, B_imag_in,
      output ld_en, ld_addr, ld_real, ld_imag,
      input  A_real_out, A_imag_out, B_real_out, B_imag_out,
      input  rd_valid, bank_sel
   );

   modport slave (
      input  swap, rd_en, A_addr, B_addr,
      input  wr_en, singlewrite, WA_addr, WB_addr,
      input  A_real_in, A_imag_in, B_real_in, B_imag_in,
      input  ld_en, ld_addr, ld_real, ld_imag,
      output A_real_out, A_imag_out, B_real_out, B_imag_out,
      output rd_valid, bank_sel
   );
endinterface

// File: rtl/mu_pingpong.sv
// Ping-pong complex memory for an in-place radix-2 FFT: butterflies read one
// bank and write the other; a swap pulse exchanges the two roles.
module mu_pingpong #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 5,
   parameter bit BITREV_LOAD = 1'b1
) (
   input logic          clk,
   input logic          rst,
   mu_pingpong_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_re [2][DEPTH];
   logic [DATA_WIDTH-1:0] mem_im [2][DEPTH];

   logic                  bank_sel;
   logic                  wr_bank;
   logic                  rd_valid;
   logic [ADDR_WIDTH-1:0] ld_eff;
   logic [DATA_WIDTH-1:0] a_re_q, a_im_q, b_re_q, b_im_q;

   assign wr_bank = ~bank_sel;

   always_comb begin
      ld_eff = bus.ld_addr;
      if (BITREV_LOAD) begin
         for (int i = 0; i < ADDR_WIDTH; i++) begin
            ld_eff[i] = bus.ld_addr[ADDR_WIDTH-1-i];
         end
      end
   end

   // Port B is written after port A so it wins on an address clash; loads
   // always hit the read bank, so they never collide with butterfly writes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (bus.wr_en) begin
            mem_re[wr_bank][bus.WA_addr] <= bus.A_real_in;
            mem_im[wr_bank][bus.WA_addr] <= bus.A_imag_in;
            if (!bus.singlewrite) begin
               mem_re[wr_bank][bus.WB_addr] <= bus.B_real_in;
               mem_im[wr_bank][bus.WB_addr] <= bus.B_imag_in;
            end
         end
         if (bus.ld_en) begin
            mem_re[bank_sel][ld_eff] <= bus.ld_real;
            mem_im[bank_sel][ld_eff] <= bus.ld_imag;
         end
      end
   end

   // Reads sample the array before this edge's writes land, giving read-first.
   always_ff @(posedge clk) begin
      if (rst) begin
         bank_sel <= 1'b0;
         rd_valid <= 1'b0;
         a_re_q   <= '0;
         a_im_q   <= '0;
         b_re_q   <= '0;
         b_im_q   <= '0;
      end else begin
         rd_valid <= bus.rd_en;
         if (bus.rd_en) begin
            a_re_q <= mem_re[bank_sel][bus.A_addr];
            a_im_q <= mem_im[bank_sel][bus.A_addr];
            b_re_q <= mem_re[bank_sel][bus.B_addr];
            b_im_q <= mem_im[bank_sel][bus.B_addr];
         end
         if (bus.swap) begin
            bank_sel <= ~bank_sel;
         end
      end
   end

   assign bus.bank_sel   = bank_sel;
   assign bus.rd_valid   = rd_valid;
   assign bus.A_real_out = a_re_q;
   assign bus.A_imag_out = a_im_q;
   assign bus.B_real_out = b_re_q;
   assign bus.B_imag_out = b_im_q;
endmodule

// File: tb/tb_mu_pingpong.sv
// Directed bench for mu_pingpong: fills both banks with known patterns, then
// runs a table of one-cycle vectors with hand-computed expected outputs.
module tb_mu_pingpong;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mu_pingpong_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) bus ();

   mu_pingpong #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .BITREV_LOAD(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        rst, swap, rd_en, wr_en, single, ld_en;
      logic [4:0]  a_addr, b_addr, wa, wb, ld_addr;
      logic [15:0] wa_re, wa_im, wb_re, wb_im, ld_re, ld_im;
      logic        chk_data, exp_sel, exp_valid;
      logic [15:0] e_ar, e_ai, e_br, e_bi;
   } vec_t;

   vec_t vecs[$];
   vec_t v;

   function automatic vec_t blank();
      vec_t b;
      b = '{default: '0};
      return b;
   endfunction

   function automatic vec_t expd(vec_t x, logic sel, logic valid,
                                 logic [15:0] ar, logic [15:0] ai,
                                 logic [15:0] br, logic [15:0] bi);
      vec_t y;
      y = x;
      y.chk_data  = 1'b1;
      y.exp_sel   = sel;
      y.exp_valid = valid;
      y.e_ar = ar; y.e_ai = ai; y.e_br = br; y.e_bi = bi;
      return y;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t x);
      rst             = x.rst;
      bus.swap        = x.swap;
      bus.rd_en       = x.rd_en;
      bus.A_addr      = x.a_addr;
      bus.B_addr      = x.b_addr;
      bus.wr_en       = x.wr_en;
      bus.singlewrite = x.single;
      bus.WA_addr     = x.wa;
      bus.WB_addr     = x.wb;
      bus.A_real_in   = x.wa_re;
      bus.A_imag_in   = x.wa_im;
      bus.B_real_in   = x.wb_re;
      bus.B_imag_in   = x.wb_im;
      bus.ld_en       = x.ld_en;
      bus.ld_addr     = x.ld_addr;
      bus.ld_real     = x.ld_re;
      bus.ld_imag     = x.ld_im;
      @(posedge clk);
      #1;
   endtask

   initial begin
      applyStimulus(blank());

      // Reset for two cycles, then check the reset state.
      v = blank(); v.rst = 1'b1;
      applyStimulus(v);
      applyStimulus(v);
      checkOutput("reset_bank_sel", {31'd0, bus.bank_sel}, 32'd0);
      checkOutput("reset_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
      checkOutput("reset_A_out", {bus.A_real_out, bus.A_imag_out}, 32'd0);
      checkOutput("reset_B_out", {bus.B_real_out, bus.B_imag_out}, 32'd0);

      v = blank(); v.rd_en = 1'b1;
      applyStimulus(v);
      checkOutput("idle_read_valid", {31'd0, bus.rd_valid}, 32'd1);
      applyStimulus(blank());
      checkOutput("idle_read_valid_drop", {31'd0, bus.rd_valid}, 32'd0);

      // Fill: bank0[a] = 0x1000+rev(a)/0x2000+rev(a) via loads,
      // bank1[a] = 0x3000+a/0x4000+a via paired writes in the same cycles.
      for (int k = 0; k < 32; k++) begin
         v = blank();
         v.ld_en = 1'b1; v.ld_addr = 5'(k);
         v.ld_re = 16'h1000 + 16'(k); v.ld_im = 16'h2000 + 16'(k);
         if (k < 16) begin
            v.wr_en = 1'b1; v.wa = 5'(2*k); v.wb = 5'(2*k+1);
            v.wa_re = 16'h3000 + 16'(2*k);   v.wa_im = 16'h4000 + 16'(2*k);
            v.wb_re = 16'h3000 + 16'(2*k+1); v.wb_im = 16'h4000 + 16'(2*k+1);
         end
         applyStimulus(v);
      end

      // V1: bit-reversed load of ld_addr=1 lands at address 16 of bank0
      v = blank(); v.ld_en = 1; v.ld_addr = 5'd1; v.ld_re = 16'h0011; v.ld_im = 16'h0022;
      v = expd(v, 0, 0, 0, 0, 0, 0); v.chk_data = 1'b0; vecs.push_back(v);
      // V2
      v = blank(); v.rd_en = 1; v.a_addr = 5'd16; v.b_addr = 5'd1;
      vecs.push_back(expd(v, 0, 1, 16'h0011, 16'h0022, 16'h1010, 16'h2010));
      // V3: write bank1 while reading old bank0 contents
      v = blank(); v.rd_en = 1; v.a_addr = 5'd3; v.b_addr = 5'd7;
      v.wr_en = 1; v.wa = 5'd3; v.wb = 5'd7;
      v.wa_re = 16'h1234; v.wa_im = 16'h0001; v.wb_re = 16'h5678; v.wb_im = 16'h0002;
      vecs.push_back(expd(v, 0, 1, 16'h1018, 16'h2018, 16'h101C, 16'h201C));
      // V4
      v = blank(); v.rd_en = 1; v.a_addr = 5'd3; v.b_addr = 5'd7;
      vecs.push_back(expd(v, 0, 1, 16'h1018, 16'h2018, 16'h101C, 16'h201C));
      // V5: swap, outputs hold
      v = blank(); v.swap = 1;
      vecs.push_back(expd(v, 1, 0, 16'h1018, 16'h2018, 16'h101C, 16'h201C));
      // V6
      v = blank(); v.rd_en = 1; v.a_addr = 5'd3; v.b_addr = 5'd7;
      vecs.push_back(expd(v, 1, 1, 16'h1234, 16'h0001, 16'h5678, 16'h0002));
      // V7: singlewrite into bank0, address 9 must stay untouched
      v = blank(); v.wr_en = 1; v.single = 1; v.wa = 5'd5; v.wb = 5'd9;
      v.wa_re = 16'h0A05; v.wa_im = 16'h0B05; v.wb_re = 16'hDEAD; v.wb_im = 16'hBEEF;
      vecs.push_back(expd(v, 1, 0, 16'h1234, 16'h0001, 16'h5678, 16'h0002));
      // V8: same-address collision, port B wins
      v = blank(); v.wr_en = 1; v.wa = 5'd4; v.wb = 5'd4;
      v.wa_re = 16'h00AA; v.wa_im = 16'h00A1; v.wb_re = 16'h00BB; v.wb_im = 16'h00B1;
      vecs.push_back(expd(v, 1, 0, 16'h1234, 16'h0001, 16'h5678, 16'h0002));
      // V9
      v = blank(); v.swap = 1;
      vecs.push_back(expd(v, 0, 0, 16'h1234, 16'h0001, 16'h5678, 16'h0002));
      // V10
      v = blank(); v.rd_en = 1; v.a_addr = 5'd5; v.b_addr = 5'd9;
      vecs.push_back(expd(v, 0, 1, 16'h0A05, 16'h0B05, 16'h1012, 16'h2012));
      // V11
      v = blank(); v.rd_en = 1; v.a_addr = 5'd4; v.b_addr = 5'd9;
      vecs.push_back(expd(v, 0, 1, 16'h00BB, 16'h00B1, 16'h1012, 16'h2012));
      // V12: swap and write in one cycle, write uses the pre-swap bank (bank1)
      v = blank(); v.swap = 1; v.wr_en = 1; v.single = 1; v.wa = 5'd2;
      v.wa_re = 16'h0F0F; v.wa_im = 16'hF0F0;
      vecs.push_back(expd(v, 1, 0, 16'h00BB, 16'h00B1, 16'h1012, 16'h2012));
      // V13
      v = blank(); v.rd_en = 1; v.a_addr = 5'd2; v.b_addr = 5'd3;
      vecs.push_back(expd(v, 1, 1, 16'h0F0F, 16'hF0F0, 16'h1234, 16'h0001));
      // V14: read and load hit bank1[16] together, read returns old data
      v = blank(); v.rd_en = 1; v.a_addr = 5'd16; v.b_addr = 5'd0;
      v.ld_en = 1; v.ld_addr = 5'd1; v.ld_re = 16'h7777; v.ld_im = 16'h8888;
      vecs.push_back(expd(v, 1, 1, 16'h3010, 16'h4010, 16'h3000, 16'h4000));
      // V15
      v = blank(); v.rd_en = 1; v.a_addr = 5'd16; v.b_addr = 5'd2;
      vecs.push_back(expd(v, 1, 1, 16'h7777, 16'h8888, 16'h0F0F, 16'hF0F0));
      // V16-V17: back-to-back swaps; reads use the pre-swap bank
      v = blank(); v.swap = 1; v.rd_en = 1; v.a_addr = 5'd16; v.b_addr = 5'd16;
      vecs.push_back(expd(v, 0, 1, 16'h7777, 16'h8888, 16'h7777, 16'h8888));
      vecs.push_back(expd(v, 1, 1, 16'h0011, 16'h0022, 16'h0011, 16'h0022));
      // V18: reset beats everything and suppresses write/load
      v = blank(); v.rst = 1; v.swap = 1; v.rd_en = 1; v.a_addr = 5'd2; v.b_addr = 5'd3;
      v.wr_en = 1; v.wa = 5'd6; v.wb = 5'd6;
      v.wa_re = 16'h6666; v.wa_im = 16'h6666; v.wb_re = 16'h6666; v.wb_im = 16'h6666;
      v.ld_en = 1; v.ld_addr = 5'd0; v.ld_re = 16'h5555; v.ld_im = 16'h5555;
      vecs.push_back(expd(v, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
      // V19
      v = blank(); v.rd_en = 1; v.a_addr = 5'd6; v.b_addr = 5'd0;
      vecs.push_back(expd(v, 0, 1, 16'h100C, 16'h200C, 16'h1000, 16'h2000));
      // V20
      v = blank(); v.swap = 1;
      vecs.push_back(expd(v, 1, 0, 16'h100C, 16'h200C, 16'h1000, 16'h2000));
      // V21
      v = blank(); v.rd_en = 1; v.a_addr = 5'd0; v.b_addr = 5'd6;
      vecs.push_back(expd(v, 1, 1, 16'h3000, 16'h4000, 16'h3006, 16'h4006));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("v%0d_bank_sel", i + 1), {31'd0, bus.bank_sel}, {31'd0, vecs[i].exp_sel});
         checkOutput($sformatf("v%0d_rd_valid", i + 1), {31'd0, bus.rd_valid}, {31'd0, vecs[i].exp_valid});
         if (vecs[i].chk_data) begin
            checkOutput($sformatf("v%0d_A_out", i + 1), {bus.A_real_out, bus.A_imag_out},
                        {vecs[i].e_ar, vecs[i].e_ai});
            checkOutput($sformatf("v%0d_B_out", i + 1), {bus.B_real_out, bus.B_imag_out},
                        {vecs[i].e_br, vecs[i].e_bi});
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
